// File: rtl/cgra_arb_pkg.sv
// Shared types and helpers for the CGRA ingress arbiter.
// Provides the FSM state enum, stats counter width and round-robin step.
package cgra_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STATS_CNT_W = 32;

  function automatic int rr_next(
    input int ptr,
    input int n
  );
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cgra_rr_picker.sv
// Combinational round-robin picker: first set req at or after ptr.
// Ports: req, ptr in; gnt (one-hot), idx, any out.
module cgra_rr_picker #(
  parameter  int N_SRC = 4,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      j = (int'(ptr) + k) % N_SRC;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/cgra_ingress_arbiter.sv
// Round-robin burst arbiter feeding the CGRA ingress AXIS bridge.
// Ports: clk, rst (sync, high), arb_en, s_axis_* per source, m_axis_*
// with tid, grant_vld/grant_src. CGRA_INGRESS_ARB_STATS_EN adds
// stats_clr, stats_beats, stats_stall.
module cgra_ingress_arbiter
  import cgra_arb_pkg::*;
#(
  parameter  int N_SRC     = 4,
  parameter  int AXIS_W    = 192,
  parameter  int MAX_BURST = 8,
  localparam int SRC_W     = $clog2(N_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  input  logic [N_SRC-1:0][AXIS_W-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]             s_axis_tvalid,
  output logic [N_SRC-1:0]             s_axis_tready,
  output logic [AXIS_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [SRC_W-1:0]             m_axis_tid,
  output logic                         grant_vld,
  output logic [SRC_W-1:0]             grant_src
`ifdef CGRA_INGRESS_ARB_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [N_SRC-1:0][STATS_CNT_W-1:0] stats_beats,
  output logic [STATS_CNT_W-1:0]       stats_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state;
  arb_state_e       state_d;
  logic [SRC_W-1:0] rr_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic [N_SRC-1:0] gnt_oh;

  logic [N_SRC-1:0] pick_gnt;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;

  logic out_ok;
  logic src_vld;
  logic accept;
  logic last;
  logic rel;

  cgra_rr_picker #(
    .N_SRC(N_SRC)
  ) u_picker (
    .req(s_axis_tvalid),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  // gnt_oh mirrors grant_src as a mask so ready/valid need no decoder
  always_comb begin
    out_ok  = !m_axis_tvalid || m_axis_tready;
    src_vld = |(s_axis_tvalid & gnt_oh);
    accept  = (state == GRANT) && src_vld && out_ok;
    last    = accept && (int'(burst_cnt) + 1 == MAX_BURST);
    state_d = state;
    rel     = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_en && pick_any) state_d = GRANT;
      end
      GRANT: begin
        rel = last
            || (!src_vld && out_ok)
            || (!arb_en && !accept);
        if (rel) state_d = IDLE;
      end
    endcase
    s_axis_tready = '0;
    if (state == GRANT && out_ok) s_axis_tready = gnt_oh;
  end

  assign grant_vld = (state == GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      grant_src     <= '0;
      gnt_oh        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && state_d == GRANT) begin
        grant_src <= pick_idx;
        gnt_oh    <= pick_gnt;
        burst_cnt <= '0;
      end else if (rel) begin
        burst_cnt <= '0;
        rr_ptr    <= SRC_W'(rr_next(int'(grant_src), N_SRC));
      end else if (accept) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata[grant_src];
        m_axis_tid    <= grant_src;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef CGRA_INGRESS_ARB_STATS_EN
  localparam logic [STATS_CNT_W-1:0] SAT = '1;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stats_beats <= '0;
      stats_stall <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (accept && gnt_oh[i] && stats_beats[i] != SAT)
          stats_beats[i] <= stats_beats[i] + 1'b1;
      end
      if (m_axis_tvalid && !m_axis_tready && stats_stall != SAT)
        stats_stall <= stats_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cgra_ingress_arbiter.sv
// Randomized bench for cgra_ingress_arbiter with a behavioural model.
// Directed sequences pin the model with hand-computed values.
module tb_cgra_ingress_arbiter;

  localparam int N  = 4;
  localparam int W  = 192;
  localparam int MB = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst, arb_en, m_rdy;
  logic [N-1:0][W-1:0] sd;
  logic [N-1:0] sv, sr;
  logic [W-1:0] md;
  logic mv, gv;
  logic [SW-1:0] mt, gs;
`ifdef CGRA_INGRESS_ARB_STATS_EN
  logic sclr;
  logic [N-1:0][31:0] sb;
  logic [31:0] ss;
`endif

  always #5 clk = ~clk;

  cgra_ingress_arbiter #(
    .N_SRC(N), .AXIS_W(W), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .s_axis_tdata(sd), .s_axis_tvalid(sv),
    .s_axis_tready(sr),
    .m_axis_tdata(md), .m_axis_tvalid(mv),
    .m_axis_tready(m_rdy), .m_axis_tid(mt),
    .grant_vld(gv), .grant_src(gs)
`ifdef CGRA_INGRESS_ARB_STATS_EN
    , .stats_clr(sclr), .stats_beats(sb),
    .stats_stall(ss)
`endif
  );

  int vecs = 0;
  int errs = 0;

  // Model: grant owner, burst count, pointer and one output slot
  bit e_gr, e_ov;
  int e_gs, e_cnt, e_rr, e_ot;
  logic [W-1:0] e_od;
`ifdef CGRA_INGRESS_ARB_STATS_EN
  longint e_sb[N];
  longint e_ss;
`endif

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rdata();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++)
      d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    e_gr = 0; e_ov = 0; e_gs = 0; e_cnt = 0;
    e_rr = 0; e_ot = 0; e_od = '0;
`ifdef CGRA_INGRESS_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_sb[i] = 0;
    e_ss = 0;
`endif
  endtask

  task automatic model_check();
    logic [N-1:0] er;
    er = '0;
    if (e_gr && (!e_ov || m_rdy)) er[e_gs] = 1'b1;
    chk("s_tready", sr, er);
    chk("grant_vld", gv, e_gr);
    chk("grant_src", gs, e_gs);
    chk("m_tvalid", mv, e_ov);
    chk("m_tdata", md, e_od);
    chk("m_tid", mt, e_ot);
`ifdef CGRA_INGRESS_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("stats_beats", sb[i], e_sb[i]);
    chk("stats_stall", ss, e_ss);
`endif
  endtask

  task automatic model_step();
    bit ok, acc, rel, found;
    int j;
    if (rst) begin
      model_reset();
      return;
    end
    ok  = !e_ov || m_rdy;
    acc = e_gr && sv[e_gs] && ok;
`ifdef CGRA_INGRESS_ARB_STATS_EN
    if (sclr) begin
      for (int i = 0; i < N; i++) e_sb[i] = 0;
      e_ss = 0;
    end else begin
      if (acc && e_sb[e_gs] < 64'hFFFF_FFFF)
        e_sb[e_gs]++;
      if (e_ov && !m_rdy && e_ss < 64'hFFFF_FFFF)
        e_ss++;
    end
`endif
    if (acc) begin
      e_ov = 1; e_od = sd[e_gs]; e_ot = e_gs;
    end else if (m_rdy) begin
      e_ov = 0;
    end
    if (!e_gr) begin
      found = 0;
      if (arb_en) begin
        for (int k = 0; k < N; k++) begin
          j = (e_rr + k) % N;
          if (!found && sv[j]) begin
            found = 1; e_gs = j;
          end
        end
      end
      if (found) begin
        e_gr = 1; e_cnt = 0;
      end
    end else begin
      if (acc) e_cnt++;
      rel = (acc && e_cnt == MB)
         || (!sv[e_gs] && ok)
         || (!arb_en && !acc);
      if (rel) begin
        e_gr = 0; e_cnt = 0;
        e_rr = (e_gs + 1) % N;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    model_step();
    vecs++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int tids[$];
    int exp_tids[10];
    int dens, rdy_p, en_p;
    exp_tids = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    rst = 1'b1; arb_en = 1'b0; m_rdy = 1'b0;
    sv = '0; sd = '0;
`ifdef CGRA_INGRESS_ARB_STATS_EN
    sclr = 1'b0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_tvalid", mv, 0);
    chk("rst_tdata", md, 0);
    chk("rst_tid", mt, 0);
    chk("rst_tready", sr, 0);
    chk("rst_gvld", gv, 0);
    chk("rst_gsrc", gs, 0);

    // src0 three beats, MAX_BURST=2 splits them 2+1
    arb_en = 1; m_rdy = 1;
    sv = 4'b0001; sd[0] = W'('hA0);
    cycle();
    cycle();
    chk("d1_valid", mv, 1);
    chk("d1_data", md, W'('hA0));
    chk("d1_tid", mt, 0);
    sd[0] = W'('hA1);
    cycle();
    chk("d1_data2", md, W'('hA1));
    sd[0] = W'('hA2);
    cycle();
    chk("d1_bubble", mv, 0);
    cycle();
    chk("d1_data3", md, W'('hA2));
    sv = '0;
    cycle();
    sv = 4'b0011;
    cycle();
    chk("d1_rr_gvld", gv, 1);
    chk("d1_rr_gsrc", gs, 1);

    // all sources valid: pairs of tids with bubbles
    do_reset();
    sv = 4'hF;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < N; i++) sd[i] = rdata();
      cycle();
      if (mv) tids.push_back(int'(mt));
    end
    chk("d2_count", (tids.size() >= 10), 1);
    for (int i = 0; i < 10 && i < tids.size(); i++)
      chk("d2_tid_seq", tids[i], exp_tids[i]);

    // reset while granted with a beat held
    m_rdy = 0;
    cycle();
    chk("d5_pre_valid", mv, 1);
    do_reset();
    chk("d5_tvalid", mv, 0);
    chk("d5_tdata", md, 0);
    chk("d5_tready", sr, 0);
    chk("d5_gvld", gv, 0);
    m_rdy = 1; sv = 4'hF;
    cycle();
    chk("d5_first_src0", gs, 0);

    // src2 burst with a 5-cycle downstream stall
    do_reset();
    sv = 4'b0100;
    for (int c = 0; c < 14; c++) begin
      m_rdy = !(c >= 3 && c < 8);
      sd[2] = rdata();
      cycle();
    end

    // arb_en falls during src1 burst, rises later
    do_reset();
    m_rdy = 1; sv = 4'b0110;
    cycle();
    cycle();
    arb_en = 0;
    for (int c = 0; c < 5; c++) begin
      sd[1] = rdata();
      cycle();
    end
    chk("d4_no_grant", gv, 0);
    arb_en = 1;
    cycle();
    chk("d4_resume", gs, 2);

`ifdef CGRA_INGRESS_ARB_STATS_EN
    sv = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      m_rdy = (c % 5 != 2);
      sd[3] = rdata();
      cycle();
    end
    sclr = 1;
    cycle();
    sclr = 0;
    chk("st_clr_beats", sb[3], 0);
    chk("st_clr_stall", ss, 0);
`endif

    // randomized phases
    for (int ph = 0; ph < 4; ph++) begin
      dens  = 30 + ph * 20;
      rdy_p = 90 - ph * 20;
      en_p  = 95 - ph * 5;
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < N; i++) begin
          sv[i] = ($urandom_range(0, 99) < dens);
          sd[i] = rdata();
        end
        m_rdy  = ($urandom_range(0, 99) < rdy_p);
        arb_en = ($urandom_range(0, 99) < en_p);
        rst    = ($urandom_range(0, 299) == 0);
`ifdef CGRA_INGRESS_ARB_STATS_EN
        sclr   = ($urandom_range(0, 199) == 0);
`endif
        cycle();
      end
      rst = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
